// File: rtl/wave_key_sel.sv
// wave_key_sel -- two-button waveform selector for the DDS controller.
//
// Each raw push-button (active-low, asynchronous) is synchronised, debounced
// with a saturating counter and turned into a single-cycle press flag. The
// flags step a four-state selector forward (key_next) or backward (key_prev)
// through sine, square, triangle and sawtooth.
//
// Ports:
//   sys_clk    in   system clock, all state on its rising edge
//   sys_rst    in   asynchronous reset, active-high
//   key_next   in   raw button, active-low: select next waveform
//   key_prev   in   raw button, active-low: select previous waveform
//   wave_sel   out  registered one-hot select: 0001 sine, 0010 square,
//                   0100 triangle, 1000 sawtooth
//   sel_change out  registered pulse, high in the first cycle wave_sel
//                   shows a new value
module wave_key_sel #(
  parameter int unsigned      CNT_W   = 20,
  parameter logic [CNT_W-1:0] CNT_MAX = 20'd999_999
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       key_next,
  input  logic       key_prev,
  output logic [3:0] wave_sel,
  output logic       sel_change
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  // The flag fires on the sample that would take the count to CNT_MAX, so a
  // held key yields exactly one flag and then sits at saturation.
  localparam logic [CNT_W-1:0] CNT_PRE = CNT_MAX - CNT_ONE;

  localparam int unsigned NumKeys = 2;
  localparam int unsigned KeyNext = 0;
  localparam int unsigned KeyPrev = 1;

  typedef enum logic [1:0] {
    StSin = 2'd0,
    StSqu = 2'd1,
    StTri = 2'd2,
    StSaw = 2'd3
  } state_e;

  // ---------------------------------------------------------------------------
  // Key synchronisers, debounce counters and press flags
  // ---------------------------------------------------------------------------
  logic [NumKeys-1:0]            key_raw;
  logic [NumKeys-1:0]            sync_meta_q;
  logic [NumKeys-1:0]            sync_q;
  logic [NumKeys-1:0][CNT_W-1:0] cnt_q;
  logic [NumKeys-1:0][CNT_W-1:0] cnt_d;
  logic [NumKeys-1:0]            flag_q;
  logic [NumKeys-1:0]            flag_d;

  assign key_raw[KeyNext] = key_next;
  assign key_raw[KeyPrev] = key_prev;

  // Both keys share this logic but never interact: each index only reads and
  // writes its own synchroniser, counter and flag.
  always_comb begin
    cnt_d  = cnt_q;
    flag_d = '0;
    for (int i = 0; i < NumKeys; i++) begin
      if (sync_q[i]) begin
        // Released: any partial count is discarded.
        cnt_d[i] = '0;
      end else begin
        if (cnt_q[i] != CNT_MAX) begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        end
        flag_d[i] = (cnt_q[i] == CNT_PRE);
      end
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      sync_meta_q <= '1;
      sync_q      <= '1;
      cnt_q       <= '0;
      flag_q      <= '0;
    end else begin
      sync_meta_q <= key_raw;
      sync_q      <= sync_meta_q;
      cnt_q       <= cnt_d;
      flag_q      <= flag_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Waveform selector FSM
  // ---------------------------------------------------------------------------
  state_e     state_q;
  state_e     state_d;
  logic       step_next;
  logic       step_prev;
  logic [3:0] wave_sel_q;
  logic [3:0] wave_sel_d;
  logic       sel_change_q;
  logic       sel_change_d;

  // Simultaneous flags cancel out.
  assign step_next = flag_q[KeyNext] & ~flag_q[KeyPrev];
  assign step_prev = flag_q[KeyPrev] & ~flag_q[KeyNext];

  function automatic logic [3:0] decode_wave(input state_e s);
    logic [3:0] w;
    case (s)
      StSin:   w = 4'b0001;
      StSqu:   w = 4'b0010;
      StTri:   w = 4'b0100;
      StSaw:   w = 4'b1000;
      default: w = 4'b0001;
    endcase
    return w;
  endfunction

  always_comb begin
    state_d = state_q;
    case (state_q)
      StSin: begin
        if (step_next) begin
          state_d = StSqu;
        end else if (step_prev) begin
          state_d = StSaw;
        end
      end
      StSqu: begin
        if (step_next) begin
          state_d = StTri;
        end else if (step_prev) begin
          state_d = StSin;
        end
      end
      StTri: begin
        if (step_next) begin
          state_d = StSaw;
        end else if (step_prev) begin
          state_d = StSqu;
        end
      end
      StSaw: begin
        if (step_next) begin
          state_d = StSin;
        end else if (step_prev) begin
          state_d = StTri;
        end
      end
      default: state_d = StSin;
    endcase
  end

  // Outputs are registered alongside the state, so they move on the same edge.
  // sel_change compares the decoded select itself, so a recovery from a bad
  // state encoding (which still decodes to sine) never pulses it.
  always_comb begin
    wave_sel_d   = decode_wave(state_d);
    sel_change_d = (wave_sel_d != wave_sel_q);
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q      <= StSin;
      wave_sel_q   <= 4'b0001;
      sel_change_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wave_sel_q   <= wave_sel_d;
      sel_change_q <= sel_change_d;
    end
  end

  assign wave_sel   = wave_sel_q;
  assign sel_change = sel_change_q;

endmodule

// File: tb/tb_wave_key_sel.sv
// Directed bench for wave_key_sel with a short debounce (CNT_MAX = 4).
// Inputs change 1 ns after a rising edge; outputs are checked at the same
// point, well away from the next edge.
module tb_wave_key_sel;

  logic       sys_clk;
  logic       sys_rst;
  logic       key_next;
  logic       key_prev;
  logic [3:0] wave_sel;
  logic       sel_change;

  int n_checks;
  int n_fail;

  wave_key_sel #(
    .CNT_W  (3),
    .CNT_MAX(3'd4)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .key_next  (key_next),
    .key_prev  (key_prev),
    .wave_sel  (wave_sel),
    .sel_change(sel_change)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [3:0] w_exp, input logic c_exp);
    n_checks++;
    assert (wave_sel === w_exp)
    else begin
      n_fail++;
      $error("FAIL %s wave_sel observed %b expected %b", tag, wave_sel, w_exp);
    end
    n_checks++;
    assert (sel_change === c_exp)
    else begin
      n_fail++;
      $error("FAIL %s sel_change observed %b expected %b", tag, sel_change, c_exp);
    end
  endtask

  // Drive the selected keys low so the next rising edge (edge k) samples them,
  // hold for 10 edges, then release. The select moves on edge k+6 only.
  task automatic press(input string tag, input logic nxt, input logic prv,
                       input logic [3:0] old_w, input logic [3:0] new_w);
    logic [3:0] w_exp;
    logic       c_exp;
    key_next = ~nxt;
    key_prev = ~prv;
    for (int j = 0; j < 10; j++) begin
      tick();
      w_exp = (j >= 6) ? new_w : old_w;
      c_exp = (j == 6) && (new_w != old_w);
      check($sformatf("%s_hold%0d", tag, j), w_exp, c_exp);
    end
    key_next = 1'b1;
    key_prev = 1'b1;
    for (int j = 0; j < 5; j++) begin
      tick();
      check($sformatf("%s_rel%0d", tag, j), new_w, 1'b0);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    key_next = 1'b1;
    key_prev = 1'b1;
    sys_rst  = 1'b0;

    // Reset takes effect with no clock edge.
    #1 sys_rst = 1'b1;
    #1;
    check("reset_async", 4'b0001, 1'b0);
    tick();
    tick();
    sys_rst = 1'b0;

    // Idle: keys released for 20 cycles.
    for (int i = 0; i < 20; i++) begin
      tick();
      check($sformatf("idle%0d", i), 4'b0001, 1'b0);
    end

    // Four separate next presses, wrapping back to sine.
    press("next1", 1'b1, 1'b0, 4'b0001, 4'b0010);
    press("next2", 1'b1, 1'b0, 4'b0010, 4'b0100);
    press("next3", 1'b1, 1'b0, 4'b0100, 4'b1000);
    press("next4", 1'b1, 1'b0, 4'b1000, 4'b0001);

    // Move off sine, then check reset clears the select without a clock.
    press("next5", 1'b1, 1'b0, 4'b0001, 4'b0010);
    sys_rst = 1'b1;
    #1;
    check("reset_mid_state", 4'b0001, 1'b0);
    tick();
    tick();
    sys_rst = 1'b0;
    tick();
    check("reset_release", 4'b0001, 1'b0);

    // Previous from sine wraps to sawtooth, then triangle.
    press("prev1", 1'b0, 1'b1, 4'b0001, 4'b1000);
    press("prev2", 1'b0, 1'b1, 4'b1000, 4'b0100);

    // Both keys together: flags coincide and cancel.
    press("both", 1'b1, 1'b1, 4'b0100, 4'b0100);

    // Back to sine for the bounce test.
    press("prev3", 1'b0, 1'b1, 4'b0100, 4'b0010);
    press("prev4", 1'b0, 1'b1, 4'b0010, 4'b0001);

    // Bounce: 3 low / 1 high never reaches CNT_MAX consecutive low samples.
    for (int i = 0; i < 40; i++) begin
      key_next = ((i % 4) == 3);
      tick();
      check($sformatf("bounce%0d", i), 4'b0001, 1'b0);
    end
    press("after_bounce", 1'b1, 1'b0, 4'b0001, 4'b0010);

    // Reset in the middle of a held press: the count restarts afterwards.
    key_next = 1'b0;
    for (int j = 0; j < 4; j++) begin
      tick();
      check($sformatf("pre_rst%0d", j), 4'b0010, 1'b0);
    end
    sys_rst = 1'b1;
    #1;
    check("rst_mid_press", 4'b0001, 1'b0);
    tick();
    check("rst_hold0", 4'b0001, 1'b0);
    tick();
    check("rst_hold1", 4'b0001, 1'b0);
    sys_rst = 1'b0;
    press("post_rst", 1'b1, 1'b0, 4'b0001, 4'b0010);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
